// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic command issuer: operand and op_sel
// widths, op_sel encodings understood by the arithunit, the issuer FSM state
// type and the packed command word stored in the command FIFO.
// -----------------------------------------------------------------------------
package arith_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_RS2 = 2'd2;
  localparam logic [OP_W-1:0] OP_RS3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op_sel;
    logic [DATA_W-1:0] data_2;
    logic [DATA_W-1:0] data_1;
  } cmd_t;

endpackage

// File: rtl/arith_cmd_fifo.sv
// -----------------------------------------------------------------------------
// arith_cmd_fifo
// In-order command FIFO, DEPTH entries (power of two). Occupancy counter
// separates full from empty; pointers wrap naturally at DEPTH.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push, pop       write / read requests (ignored when full / empty)
//   din, dout       command in, head-of-queue command out (combinational)
//   full, empty     status flags
//   count           occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module arith_cmd_fifo
  import arith_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  cmd_t                     din,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // Push is qualified by the current full flag, so a pop in the same cycle
  // never opens room for a push on a full queue.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arith_cmd_issuer.sv
// -----------------------------------------------------------------------------
// arith_cmd_issuer
// Queues operand/op_sel commands, issues them one at a time to an external
// arithunit of fixed clock latency LAT, captures each result and holds it
// until the consumer handshakes.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_data_1/2, cmd_op_sel    command operands and operation select
//   au_data_1/2, au_op_sel      registered operands driven to the arithunit
//   au_data_out                 arithunit result
//   res_valid/res_ready         result handshake
//   res_data, res_op_sel        captured result and its op_sel
//   cmd_count                   FIFO occupancy
//   busy                        FSM active or commands queued
// -----------------------------------------------------------------------------
module arith_cmd_issuer
  import arith_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DATA_W-1:0]      cmd_data_1,
  input  logic [DATA_W-1:0]      cmd_data_2,
  input  logic [OP_W-1:0]        cmd_op_sel,
  output logic [DATA_W-1:0]      au_data_1,
  output logic [DATA_W-1:0]      au_data_2,
  output logic [OP_W-1:0]        au_op_sel,
  input  logic [DATA_W-1:0]      au_data_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_data,
  output logic [OP_W-1:0]        res_op_sel,
  output logic [$clog2(DEPTH):0] cmd_count,
  output logic                   busy
);

  localparam int CW = $clog2(LAT + 1);

  state_t        state;
  state_t        state_nx;
  logic          ready_en;
  logic          full;
  logic          empty;
  logic          push;
  logic          issue;
  logic          capture;
  logic          res_hs;
  logic [CW-1:0] wait_cnt;
  cmd_t          in_cmd;
  cmd_t          head;

  // ready_en keeps cmd_ready low while reset is held and rises on the first
  // clock edge after release.
  assign cmd_ready = ready_en && !full;
  assign push      = cmd_valid && cmd_ready;
  assign res_hs    = res_valid && res_ready;
  assign busy      = (state != IDLE) || (cmd_count != '0);

  assign in_cmd.op_sel = cmd_op_sel;
  assign in_cmd.data_2 = cmd_data_2;
  assign in_cmd.data_1 = cmd_data_1;

  arith_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (issue),
    .din   (in_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (cmd_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          issue    = 1'b1;
          state_nx = WAIT;
        end
      end
      // wait_cnt is loaded with LAT at issue, so capture falls on the
      // LAT+1-th edge after issue, once the arithunit output has settled.
      WAIT: begin
        if (wait_cnt == '0) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end
      end
      // The handshake edge doubles as the next issue edge to keep the
      // back-to-back rate at one result per LAT+2 cycles.
      HOLD: begin
        if (res_hs) begin
          if (!empty) begin
            issue    = 1'b1;
            state_nx = WAIT;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en   <= 1'b0;
      wait_cnt   <= '0;
      au_data_1  <= '0;
      au_data_2  <= '0;
      au_op_sel  <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_op_sel <= '0;
    end else begin
      ready_en <= 1'b1;
      if (issue) begin
        au_data_1 <= head.data_1;
        au_data_2 <= head.data_2;
        au_op_sel <= head.op_sel;
        wait_cnt  <= CW'(LAT);
      end else if ((state == WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
      if (capture) begin
        res_valid  <= 1'b1;
        res_data   <= au_data_out;
        res_op_sel <= au_op_sel;
      end else if (res_hs) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arith_cmd_issuer.sv
module tb_arith_cmd_issuer;
  import arith_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data_1 = '0;
  logic [15:0] cmd_data_2 = '0;
  logic [1:0]  cmd_op_sel = '0;
  logic [15:0] au_data_1;
  logic [15:0] au_data_2;
  logic [1:0]  au_op_sel;
  logic [15:0] au_data_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [1:0]  res_op_sel;
  logic [2:0]  cmd_count;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  // Back-to-back table: six commands, hand-computed results.
  logic [15:0] bb_d1  [6] = '{16'd1, 16'd7, 16'd100, 16'd20, 16'hFFFF, 16'd300};
  logic [15:0] bb_d2  [6] = '{16'd2, 16'd3, 16'd50,  16'd25, 16'd1,    16'd45};
  logic [1:0]  bb_op  [6] = '{2'd0,  2'd1,  2'd0,    2'd1,   2'd0,     2'd1};
  logic [15:0] bb_exp [6] = '{16'd3, 16'd4, 16'd150, 16'hFFFB, 16'd0,  16'd255};

  // Count / wrap tables.
  logic [15:0] cw_d1  [4] = '{16'd1, 16'd2, 16'd5, 16'd40};
  logic [15:0] cw_d2  [4] = '{16'd1, 16'd2, 16'd3, 16'd2};
  logic [1:0]  cw_op  [4] = '{2'd0,  2'd0,  2'd1,  2'd1};
  logic [15:0] cw_exp [4] = '{16'd2, 16'd4, 16'd2, 16'd38};

  logic [15:0] wr_d1  [9] = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd55, 16'd66, 16'd77, 16'd88, 16'd99};
  logic [15:0] wr_d2  [9] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
  logic [1:0]  wr_op  [9] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
  logic [15:0] wr_exp [9] = '{16'd12, 16'd20, 16'd36, 16'd40, 16'd60, 16'd60, 16'd84, 16'd80, 16'd108};

  always #5 clk = ~clk;

  // Arithunit model: one registered stage, add for op 0, subtract for op 1.
  always_ff @(posedge clk) begin
    if (au_op_sel == OP_SUB) au_data_out <= au_data_1 - au_data_2;
    else                     au_data_out <= au_data_1 + au_data_2;
  end

  arith_cmd_issuer #(
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data_1  (cmd_data_1),
    .cmd_data_2  (cmd_data_2),
    .cmd_op_sel  (cmd_op_sel),
    .au_data_1   (au_data_1),
    .au_data_2   (au_data_2),
    .au_op_sel   (au_op_sel),
    .au_data_out (au_data_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_op_sel  (res_op_sel),
    .cmd_count   (cmd_count),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    vectors++; if (cmd_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", cmd_count); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if ({au_data_1, au_data_2, au_op_sel} !== 34'd0) begin errors++; $display("FAIL rst_au: got %h/%h/%h want 0", au_data_1, au_data_2, au_op_sel); end
    vectors++; if ({res_data, res_op_sel} !== 18'd0) begin errors++; $display("FAIL rst_res: got %h/%h want 0", res_data, res_op_sel); end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_pre: got %b want 0", cmd_ready); end
    step();
    vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_first_edge: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single();
    cmd_data_1 = 16'd3; cmd_data_2 = 16'd5; cmd_op_sel = OP_ADD;
    cmd_valid = 1'b1; res_ready = 1'b1;
    step();                       // edge A: accepted
    cmd_valid = 1'b0;
    vectors++; if (cmd_count !== 3'd1) begin errors++; $display("FAIL single_count_A: got %0d want 1", cmd_count); end
    step();                       // A+1: issue
    vectors++; if ({au_data_1, au_data_2, au_op_sel} !== {16'd3, 16'd5, 2'd0}) begin errors++; $display("FAIL single_au: got %0d/%0d/%0d want 3/5/0", au_data_1, au_data_2, au_op_sel); end
    vectors++; if (cmd_count !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL single_issue_state: got count %0d busy %b want 0/1", cmd_count, busy); end
    step();                       // A+2
    vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", res_valid); end
    step();                       // A+3: result
    vectors++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid_A3: got %b want 1", res_valid); end
    vectors++; if (res_data !== 16'd8 || res_op_sel !== 2'd0) begin errors++; $display("FAIL single_result: got %0d op %0d want 8 op 0", res_data, res_op_sel); end
    step();                       // A+4: consumed
    vectors++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got valid %b busy %b want 0/0", res_valid, busy); end
  endtask

  task automatic test_back_to_back();
    int   acc = 0;
    int   got = 0;
    logic took;
    logic fifth_acc = 1'b0;
    res_ready = 1'b0;
    for (int cyc = 0; cyc < 20 && acc < 5; cyc++) begin
      cmd_valid = 1'b1;
      cmd_data_1 = bb_d1[acc]; cmd_data_2 = bb_d2[acc]; cmd_op_sel = bb_op[acc];
      took = cmd_ready;
      step();
      if (took) acc++;
    end
    cmd_data_1 = bb_d1[5]; cmd_data_2 = bb_d2[5]; cmd_op_sel = bb_op[5];
    vectors++; if (acc != 5) begin errors++; $display("FAIL b2b_fill: got %0d accepted want 5", acc); end
    step(); step();
    vectors++; if (cmd_count !== 3'd4) begin errors++; $display("FAIL b2b_count_full: got %0d want 4", cmd_count); end
    vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", cmd_ready); end
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (res_valid) begin
        vectors++;
        if (res_data !== bb_exp[got] || res_op_sel !== bb_op[got]) begin
          errors++; $display("FAIL b2b_result_%0d: got %h op %0d want %h op %0d", got, res_data, res_op_sel, bb_exp[got], bb_op[got]);
        end
        if (got == 0) begin
          vectors++; if (cmd_ready !== 1'b0 || fifth_acc) begin errors++; $display("FAIL b2b_fifth_early: ready %b accepted %b want 0/0", cmd_ready, fifth_acc); end
        end
        got++;
      end
      took = cmd_valid && cmd_ready;
      step();
      if (took) begin cmd_valid = 1'b0; fifth_acc = 1'b1; end
    end
    cmd_valid = 1'b0;
    vectors++; if (got != 6 || !fifth_acc) begin errors++; $display("FAIL b2b_drain: got %0d results fifth %b want 6/1", got, fifth_acc); end
    vectors++; if (busy !== 1'b0 || cmd_count !== 3'd0) begin errors++; $display("FAIL b2b_idle: got busy %b count %0d want 0/0", busy, cmd_count); end
  endtask

  task automatic test_hold();
    res_ready = 1'b0;
    cmd_data_1 = 16'd10; cmd_data_2 = 16'd4; cmd_op_sel = OP_SUB; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int n = 0; n < 10 && !res_valid; n++) step();
    vectors++; if (res_valid !== 1'b1) begin errors++; $display("FAIL hold_timeout: res_valid %b want 1", res_valid); end
    for (int n = 0; n < 5; n++) begin
      vectors++;
      if (res_valid !== 1'b1 || res_data !== 16'd6 || res_op_sel !== 2'd1 ||
          au_data_1 !== 16'd10 || au_data_2 !== 16'd4 || au_op_sel !== 2'd1) begin
        errors++; $display("FAIL hold_stable_%0d: got v%b d%0d op%0d au %0d/%0d/%0d want 1/6/1 au 10/4/1",
                           n, res_valid, res_data, res_op_sel, au_data_1, au_data_2, au_op_sel);
      end
      step();
    end
    res_ready = 1'b1;
    step();
    vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", res_valid); end
    step(); step();
    vectors++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hold_idle_ready: got valid %b busy %b want 0/0", res_valid, busy); end
    res_ready = 1'b0;
  endtask

  task automatic test_count_wrap();
    int   acc = 0;
    int   got = 0;
    logic took;
    res_ready = 1'b0;
    for (int cyc = 0; cyc < 20 && acc < 3; cyc++) begin
      cmd_valid = 1'b1;
      cmd_data_1 = cw_d1[acc]; cmd_data_2 = cw_d2[acc]; cmd_op_sel = cw_op[acc];
      took = cmd_ready;
      step();
      if (took) acc++;
    end
    cmd_valid = 1'b0;
    for (int n = 0; n < 10 && !res_valid; n++) step();
    vectors++; if (cmd_count !== 3'd2 || res_valid !== 1'b1 || res_data !== 16'd2) begin
      errors++; $display("FAIL cnt_setup: got count %0d valid %b data %0d want 2/1/2", cmd_count, res_valid, res_data);
    end
    // push c3 and pop c1 on the same edge
    cmd_data_1 = cw_d1[3]; cmd_data_2 = cw_d2[3]; cmd_op_sel = cw_op[3];
    cmd_valid = 1'b1; res_ready = 1'b1;
    step();
    cmd_valid = 1'b0; res_ready = 1'b0;
    vectors++; if (cmd_count !== 3'd2) begin errors++; $display("FAIL cnt_push_pop: got %0d want 2", cmd_count); end
    vectors++; if (au_data_1 !== 16'd2 || res_valid !== 1'b0) begin errors++; $display("FAIL cnt_issue_c1: got au1 %0d valid %b want 2/0", au_data_1, res_valid); end
    res_ready = 1'b1;
    got = 1;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      if (res_valid) begin
        vectors++;
        if (res_data !== cw_exp[got]) begin errors++; $display("FAIL cnt_result_%0d: got %0d want %0d", got, res_data, cw_exp[got]); end
        got++;
      end
      step();
    end
    vectors++; if (got != 4) begin errors++; $display("FAIL cnt_drain: got %0d want 4", got); end
    // 2*DEPTH+1 commands streamed through the queue
    acc = 0; got = 0;
    for (int cyc = 0; cyc < 200 && got < 9; cyc++) begin
      if (acc < 9) begin
        cmd_valid = 1'b1;
        cmd_data_1 = wr_d1[acc]; cmd_data_2 = wr_d2[acc]; cmd_op_sel = wr_op[acc];
      end else begin
        cmd_valid = 1'b0;
      end
      took = cmd_valid && cmd_ready;
      if (res_valid) begin
        vectors++;
        if (res_data !== wr_exp[got] || res_op_sel !== wr_op[got]) begin
          errors++; $display("FAIL wrap_result_%0d: got %0d op %0d want %0d op %0d", got, res_data, res_op_sel, wr_exp[got], wr_op[got]);
        end
        got++;
      end
      step();
      if (took) acc++;
    end
    cmd_valid = 1'b0;
    vectors++; if (got != 9 || acc != 9) begin errors++; $display("FAIL wrap_count: got %0d results %0d accepted want 9/9", got, acc); end
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int   acc = 0;
    logic took;
    res_ready = 1'b0;
    for (int cyc = 0; cyc < 20 && acc < 4; cyc++) begin
      cmd_valid = 1'b1;
      cmd_data_1 = bb_d1[acc]; cmd_data_2 = bb_d2[acc]; cmd_op_sel = bb_op[acc];
      took = cmd_ready;
      step();
      if (took) acc++;
    end
    cmd_valid = 1'b0;
    for (int n = 0; n < 10 && !res_valid; n++) step();
    // hand over the held result while pushing a fifth command: next one enters WAIT
    cmd_data_1 = bb_d1[4]; cmd_data_2 = bb_d2[4]; cmd_op_sel = bb_op[4];
    cmd_valid = 1'b1; res_ready = 1'b1;
    step();
    cmd_valid = 1'b0; res_ready = 1'b0;
    vectors++; if (cmd_count !== 3'd3 || res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rmid_setup: got count %0d valid %b busy %b want 3/0/1", cmd_count, res_valid, busy);
    end
    #2 reset = 1'b0;
    #1;
    vectors++; if (cmd_count !== 3'd0 || cmd_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_ctrl: got count %0d ready %b busy %b valid %b want 0/0/0/0", cmd_count, cmd_ready, busy, res_valid);
    end
    vectors++; if ({au_data_1, au_data_2, au_op_sel, res_data, res_op_sel} !== 52'd0) begin
      errors++; $display("FAIL rmid_data: got au %h/%h/%h res %h/%h want 0", au_data_1, au_data_2, au_op_sel, res_data, res_op_sel);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", cmd_ready); end
    res_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      vectors++;
      if (res_valid !== 1'b0 || cmd_count !== 3'd0 || busy !== 1'b0) begin
        errors++; $display("FAIL rmid_stale_%0d: got valid %b count %0d busy %b want 0/0/0", n, res_valid, cmd_count, busy);
      end
      step();
    end
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_count_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
